// File: rtl/fight_controller_pkg.sv
// Shared encodings for the boxing-game fight controller: round and opponent
// states, health width and the opponent LFSR step.
package fight_controller_pkg;

  localparam int HEALTH_W = 4;

  // Feedback taps for x^8+x^6+x^5+x^4+1 in shift-left Fibonacci form.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FIGHT = 2'd1,
    R_WIN   = 2'd2,
    R_LOSE  = 2'd3
  } round_t;

  typedef enum logic [1:0] {
    O_REST   = 2'd0,
    O_WINDUP = 2'd1,
    O_STRIKE = 2'd2,
    O_STUN   = 2'd3
  } opp_t;

  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/fight_controller_opp_scheduler.sv
// Opponent attack scheduler: rest -> windup -> strike -> (stun) loop with an
// LFSR-randomised rest length. Advances only while enable is high.
module fight_controller_opp_scheduler
  import fight_controller_pkg::*;
#(
  parameter int         REST_MIN  = 32,
  parameter int         WINDUP    = 16,
  parameter int         STUN      = 24,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  input  logic user_can_be_hit,
  output logic windup,
  output logic strike,
  output logic stunned,
  output logic strike_hit
);

  localparam int TIMER_W = 16;

  opp_t               state, state_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic [7:0]         lfsr, lfsr_nxt;
  logic               enter_rest;

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    lfsr_nxt   = lfsr;
    strike_hit = 1'b0;
    enter_rest = 1'b0;
    if (restart) begin
      enter_rest = 1'b1;
    end else if (enable) begin
      unique case (state)
        O_REST: begin
          if (timer == '0) begin
            state_nxt = O_WINDUP;
            timer_nxt = TIMER_W'(WINDUP - 1);
          end else begin
            timer_nxt = timer - 1'b1;
          end
        end
        O_WINDUP: begin
          if (timer == '0) state_nxt = O_STRIKE;
          else             timer_nxt = timer - 1'b1;
        end
        O_STRIKE: begin
          if (user_can_be_hit) begin
            strike_hit = 1'b1;
            enter_rest = 1'b1;
          end else begin
            state_nxt = O_STUN;
            timer_nxt = TIMER_W'(STUN - 1);
          end
        end
        O_STUN: begin
          if (timer == '0) enter_rest = 1'b1;
          else             timer_nxt  = timer - 1'b1;
        end
        default: state_nxt = O_REST;
      endcase
    end
    // Every entry into rest draws a fresh LFSR value for its length.
    if (enter_rest) begin
      state_nxt = O_REST;
      lfsr_nxt  = lfsr_step(lfsr);
      timer_nxt = TIMER_W'(REST_MIN - 1) + TIMER_W'(lfsr_nxt[3:0]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= O_REST;
      timer   <= '0;
      lfsr    <= LFSR_SEED;
      windup  <= 1'b0;
      strike  <= 1'b0;
      stunned <= 1'b0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      lfsr    <= lfsr_nxt;
      windup  <= (state_nxt == O_WINDUP);
      strike  <= (state_nxt == O_STRIKE);
      stunned <= (state_nxt == O_STUN);
    end
  end

endmodule

// File: rtl/fight_controller.sv
// Round sequencer and hit arbiter: owns both health counters, detects user
// punch edges, applies cooldown and declares win/lose.
module fight_controller
  import fight_controller_pkg::*;
#(
  parameter logic [HEALTH_W-1:0] HEALTH_MAX = 4'd10,
  parameter int                  REST_MIN   = 32,
  parameter int                  WINDUP     = 16,
  parameter int                  STUN       = 24,
  parameter int                  COOLDOWN   = 8,
  parameter logic [7:0]          LFSR_SEED  = 8'hA5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                user_lpunch,
  input  logic                user_rpunch,
  input  logic                user_can_be_hit,
  output logic [HEALTH_W-1:0] user_health,
  output logic [HEALTH_W-1:0] opp_health,
  output logic                opp_windup,
  output logic                opp_strike,
  output logic                opp_stunned,
  output logic                hit_user,
  output logic                hit_opp,
  output logic [1:0]          round_state,
  output logic                user_win,
  output logic                user_lose
);

  round_t              round_q, round_nxt;
  logic [HEALTH_W-1:0] uh_nxt, oh_nxt;
  logic [7:0]          cooldown;
  logic                lpunch_p1, rpunch_p1;
  logic                fight, restart, punch_edge, land, strike_hit;

  function automatic logic [HEALTH_W-1:0] sat_dec(input logic [HEALTH_W-1:0] h);
    return (h == '0) ? '0 : h - 1'b1;
  endfunction

  assign fight      = (round_q == R_FIGHT);
  assign restart    = !fight && start;
  assign punch_edge = (user_lpunch & ~lpunch_p1) | (user_rpunch & ~rpunch_p1);
  assign land       = fight && punch_edge && (cooldown == '0) && (opp_windup || opp_stunned);

  fight_controller_opp_scheduler #(
    .REST_MIN (REST_MIN),
    .WINDUP   (WINDUP),
    .STUN     (STUN),
    .LFSR_SEED(LFSR_SEED)
  ) u_opp (
    .clock          (clock),
    .reset          (reset),
    .enable         (fight),
    .restart        (restart),
    .user_can_be_hit(user_can_be_hit),
    .windup         (opp_windup),
    .strike         (opp_strike),
    .stunned        (opp_stunned),
    .strike_hit     (strike_hit)
  );

  always_comb begin
    round_nxt = round_q;
    uh_nxt    = user_health;
    oh_nxt    = opp_health;
    if (restart) begin
      round_nxt = R_FIGHT;
      uh_nxt    = HEALTH_MAX;
      oh_nxt    = HEALTH_MAX;
    end else if (fight) begin
      if (strike_hit) uh_nxt = sat_dec(user_health);
      if (land)       oh_nxt = sat_dec(opp_health);
      // A user knockout outranks an opponent knockout on the same edge.
      if (uh_nxt == '0)      round_nxt = R_LOSE;
      else if (oh_nxt == '0) round_nxt = R_WIN;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      round_q     <= R_IDLE;
      user_health <= HEALTH_MAX;
      opp_health  <= HEALTH_MAX;
      hit_user    <= 1'b0;
      hit_opp     <= 1'b0;
      user_win    <= 1'b0;
      user_lose   <= 1'b0;
      cooldown    <= '0;
      lpunch_p1   <= 1'b0;
      rpunch_p1   <= 1'b0;
    end else begin
      round_q     <= round_nxt;
      user_health <= uh_nxt;
      opp_health  <= oh_nxt;
      hit_user    <= fight && strike_hit;
      hit_opp     <= land;
      user_win    <= (round_nxt == R_WIN);
      user_lose   <= (round_nxt == R_LOSE);
      lpunch_p1   <= user_lpunch;
      rpunch_p1   <= user_rpunch;
      if (land)                cooldown <= 8'(COOLDOWN);
      else if (cooldown != '0) cooldown <= cooldown - 1'b1;
    end
  end

  assign round_state = round_q;

endmodule

// File: tb/tb_fight_controller.sv
// Directed bench for fight_controller with a hit-event scoreboard checked by
// an independent monitor on the falling clock edge.
module tb_fight_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       user_lpunch = 1'b0;
  logic       user_rpunch = 1'b0;
  logic       user_can_be_hit = 1'b1;
  logic [3:0] user_health, opp_health;
  logic       opp_windup, opp_strike, opp_stunned;
  logic       hit_user, hit_opp;
  logic [1:0] round_state;
  logic       user_win, user_lose;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       kind;   // 0: user took damage, 1: opponent took damage
    logic [3:0] uh;
    logic [3:0] oh;
  } ev_t;

  ev_t sb[$];
  ev_t mon_e;

  fight_controller dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .user_lpunch    (user_lpunch),
    .user_rpunch    (user_rpunch),
    .user_can_be_hit(user_can_be_hit),
    .user_health    (user_health),
    .opp_health     (opp_health),
    .opp_windup     (opp_windup),
    .opp_strike     (opp_strike),
    .opp_stunned    (opp_stunned),
    .hit_user       (hit_user),
    .hit_opp        (hit_opp),
    .round_state    (round_state),
    .user_win       (user_win),
    .user_lose      (user_lose)
  );

  always #5 clock = ~clock;

  // Monitor: every hit pulse must match the oldest expected event.
  always @(negedge clock) begin
    if (!reset && (hit_user || hit_opp)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_hit: got hit_user=%0b hit_opp=%0b uh=%0d oh=%0d, required no hit",
                 hit_user, hit_opp, user_health, opp_health);
      end else begin
        mon_e = sb.pop_front();
        if ({hit_opp, hit_user, user_health, opp_health} !==
            {mon_e.kind, ~mon_e.kind, mon_e.uh, mon_e.oh}) begin
          errors++;
          $display("FAIL hit_event: got opp=%0b user=%0b uh=%0d oh=%0d, required opp=%0b user=%0b uh=%0d oh=%0d",
                   hit_opp, hit_user, user_health, opp_health,
                   mon_e.kind, ~mon_e.kind, mon_e.uh, mon_e.oh);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push_ev(input logic kind, input logic [3:0] uh, input logic [3:0] oh);
    ev_t e;
    e.kind = kind;
    e.uh   = uh;
    e.oh   = oh;
    sb.push_back(e);
  endtask

  task automatic wait_strike();
    int n = 0;
    while (!opp_strike && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("wait_strike_timeout", n, 0);
  endtask

  task automatic wait_windup();
    int n = 0;
    while (!opp_windup && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("wait_windup_timeout", n, 0);
  endtask

  task automatic count_rest(input string name, input int exp);
    int n = 0;
    while (!opp_windup && n < 200) begin
      n++;
      tick();
    end
    chk(name, n, exp);
  endtask

  initial begin
    int m, stun_n, gap, cyc, exp_oh;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_round", round_state, 0);
    chk("rst_uh", user_health, 10);
    chk("rst_oh", opp_health, 10);
    chk("rst_flags", {opp_windup, opp_strike, opp_stunned, hit_user, hit_opp, user_win, user_lose}, 0);

    // Round start; first rest length comes from LFSR A5 -> 4A (nibble 10)
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_round", round_state, 1);
    chk("start_uh", user_health, 10);
    count_rest("rest1_len", 42);
    m = 0;
    while (opp_windup && m < 100) begin
      m++;
      tick();
    end
    chk("windup_len", m, 16);
    chk("strike_seen", opp_strike, 1);

    // Unblocked strike; next rest from LFSR 4A -> 95 (nibble 5)
    push_ev(1'b0, 4'd9, 4'd10);
    tick();
    chk("hit1_uh", user_health, 9);
    count_rest("rest2_len", 37);

    // Blocked strike -> stun, punches at stun-relative edges 1, 4, 10
    wait_strike();
    user_can_be_hit = 1'b0;
    tick();
    chk("block_stun", opp_stunned, 1);
    chk("block_uh", user_health, 9);
    stun_n = 1;
    for (int k = 1; k <= 30; k++) begin
      user_rpunch = (k == 1) || (k == 4) || (k == 10);
      if (k == 1)  push_ev(1'b1, 4'd9, 4'd9);
      if (k == 10) push_ev(1'b1, 4'd9, 4'd8);
      tick();
      if (k == 1) chk("stun_first_land", opp_health, 9);
      if (k == 4) chk("stun_cooldown_absorb", opp_health, 9);
      if (opp_stunned) stun_n++;
    end
    user_rpunch = 1'b0;
    chk("stun_len", stun_n, 24);
    chk("stun_oh", opp_health, 8);
    user_can_be_hit = 1'b1;

    // Edges during rest are absorbed
    user_lpunch = 1'b1; tick();
    user_lpunch = 1'b0; tick();
    user_rpunch = 1'b1; tick();
    user_rpunch = 1'b0; tick();
    user_lpunch = 1'b1; user_rpunch = 1'b1; tick();
    user_lpunch = 1'b0; user_rpunch = 1'b0; tick();
    chk("rest_absorb_oh", opp_health, 8);

    // Simultaneous edges in windup land once
    wait_windup();
    user_lpunch = 1'b1;
    user_rpunch = 1'b1;
    push_ev(1'b1, 4'd9, 4'd7);
    tick();
    user_lpunch = 1'b0;
    user_rpunch = 1'b0;
    tick();
    chk("dual_punch_oh", opp_health, 7);

    // Strikes down to zero health -> LOSE
    for (int i = 8; i >= 0; i--) begin
      wait_strike();
      push_ev(1'b0, 4'(i), 4'd7);
      tick();
    end
    chk("lose_round", round_state, 3);
    chk("lose_flag", user_lose, 1);
    chk("lose_win_flag", user_win, 0);
    chk("lose_uh", user_health, 0);
    for (int k = 0; k < 40; k++) begin
      user_lpunch = k[1];
      tick();
    end
    user_lpunch = 1'b0;
    chk("lose_frozen", {round_state, user_health, opp_health}, {2'd3, 4'd0, 4'd7});

    // Restart from LOSE, then punch the opponent out while always blocking
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_round", round_state, 1);
    chk("restart_health", {user_health, opp_health}, {4'd10, 4'd10});
    user_can_be_hit = 1'b0;
    exp_oh = 10;
    gap = 100;
    cyc = 0;
    while (exp_oh > 0 && cyc < 3000) begin
      user_lpunch = 1'b0;
      if ((opp_windup || opp_stunned) && gap >= 9) begin
        user_lpunch = 1'b1;
        exp_oh--;
        push_ev(1'b1, 4'd10, 4'(exp_oh));
        gap = 0;
      end
      tick();
      gap++;
      cyc++;
    end
    user_lpunch = 1'b0;
    chk("win_loop_bound", cyc < 3000, 1);
    chk("win_round", round_state, 2);
    chk("win_flag", {user_win, user_lose}, 2'b10);
    chk("win_health", {user_health, opp_health}, {4'd10, 4'd0});
    for (int k = 0; k < 20; k++) tick();
    chk("win_hold", round_state, 2);

    // Restart from WIN, take five hits, reset mid-windup
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rewin_health", {round_state, user_health, opp_health}, {2'd1, 4'd10, 4'd10});
    user_can_be_hit = 1'b1;
    for (int i = 9; i >= 5; i--) begin
      wait_strike();
      push_ev(1'b0, 4'(i), 4'd10);
      tick();
    end
    chk("pre_reset_uh", user_health, 5);
    wait_windup();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_round", round_state, 0);
    chk("midrst_health", {user_health, opp_health}, {4'd10, 4'd10});
    chk("midrst_flags", {opp_windup, opp_strike, opp_stunned, hit_user, hit_opp, user_win, user_lose}, 0);

    // LFSR back at its seed: first rest length repeats
    start = 1'b1;
    tick();
    start = 1'b0;
    count_rest("rest_after_reset_len", 42);

    tick();
    tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fight_controller.md
Name: fight_controller

Overview:
- Round sequencer and hit arbiter for the boxing game.
- Consumes the user FSM outputs (lpunch, rpunch, can_be_hit) and owns both health counters. user_health feeds back to the user FSM health input.
- Schedules opponent attacks (rest → windup telegraph → strike → optional stun) using an LFSR, resolves hits in both directions, and declares the round win/lose.

Parameters:
- HEALTH_MAX, 4'd10, starting health for both fighters; must be 1..15.
- REST_MIN, 32, minimum opponent rest cycles.
- WINDUP, 16, opponent telegraph cycles.
- STUN, 24, cycles the opponent stays stunned after a blocked strike.
- COOLDOWN, 8, cycles after a landed user punch during which further punches are ignored.
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high; one clock, reset sampled on posedge clock
- start  in  1  level; begins a round from IDLE, WIN or LOSE
- user_lpunch  in  1  from user FSM
- user_rpunch  in  1  from user FSM
- user_can_be_hit  in  1  from user FSM; 0 means the user is blocking
- user_health  out  4  to user FSM health input
- opp_health  out  4  opponent health
- opp_windup  out  1  opponent telegraph, high during O_WINDUP
- opp_strike  out  1  high during O_STRIKE
- opp_stunned  out  1  high during O_STUN
- hit_user  out  1  one-cycle pulse when the user takes damage
- hit_opp  out  1  one-cycle pulse when the opponent takes damage
- round_state  out  2  IDLE=0, FIGHT=1, WIN=2, LOSE=3
- user_win  out  1  high in WIN
- user_lose  out  1  high in LOSE

Behaviour:
- Reset values:
  - round_state=IDLE; opponent FSM in O_REST.
  - Both healths = HEALTH_MAX.
  - All 1-bit outputs 0; cooldown 0; punch-history regs 0; LFSR = LFSR_SEED.
- Reset has priority over all other inputs. Reset mid-round returns to the reset values on the next edge.
- All outputs are registered.
- Top FSM:
  - IDLE → FIGHT when start=1. Both healths reload to HEALTH_MAX and the opponent enters O_REST.
  - FIGHT → LOSE when user_health reaches 0 on this edge.
  - FIGHT → WIN when opp_health reaches 0 on this edge.
  - LOSE has priority if both reach 0 on the same edge; this is unreachable by construction but must still be coded.
  - WIN/LOSE hold with healths frozen until start=1, which reloads health and enters FIGHT.
- Opponent FSM (advances only in FIGHT; frozen elsewhere):
  - O_REST: lasts REST_MIN + lfsr[3:0] cycles. The LFSR steps once on each O_REST entry, polynomial x^8+x^6+x^5+x^4+1, Fibonacci form.
  - O_WINDUP: lasts WINDUP cycles.
  - O_STRIKE: lasts exactly 1 cycle. Strike resolution is sampled in this cycle:
    - user_can_be_hit=1: user_health decrements (saturating at 0), hit_user pulses next cycle, next state O_REST.
    - user_can_be_hit=0: blocked; next state O_STUN.
  - O_STUN: lasts STUN cycles, then O_REST.
- User punches:
  - punch_edge = (lpunch & ~lpunch_d) | (rpunch & ~rpunch_d).
  - The history registers update every cycle in every state. A punch held across round entry does not count.
  - A punch edge in FIGHT lands only if cooldown==0 and the opponent is in O_WINDUP or O_STUN.
  - Landed punch: opp_health decrements (saturating at 0), hit_opp pulses the next cycle, cooldown loads COOLDOWN.
  - Edges in O_REST or O_STRIKE are absorbed with no damage and no cooldown.
  - A landed punch does not alter the opponent state or its timer.
- Cooldown decrements by 1 per cycle to 0 and does not wrap.
- Simultaneous lpunch and rpunch edges count as one hit.
- Latency: punch edge sampled at edge N → health and hit_opp updated at edge N+1.
- Health never wraps below 0 and never exceeds HEALTH_MAX.

Decomposition:
- Shared package/header fight_defs: round-state and opponent-state encodings, health width (4), LFSR taps.
- One sub-module, opp_scheduler: opponent FSM, duration counter and LFSR.
  - Inputs: clock, reset, enable (= FIGHT), restart, user_can_be_hit.
  - Outputs: state flags, strike_hit pulse.
- Top level keeps the round FSM, health counters, edge detection and cooldown.

Test Plan:
- Reset, then start=1 for 1 cycle → round_state=1, both healths=10, opponent in O_REST for 32+lfsr[3:0] cycles, then opp_windup=1 for exactly 16 cycles.
- user_can_be_hit=1 through a strike → hit_user pulses 1 cycle, user_health 10→9; 10 unblocked strikes → user_health=0, round_state=LOSE, user_lose=1, healths frozen.
- user_can_be_hit=0 during O_STRIKE → no damage, opp_stunned=1 for 24 cycles. Two rpunch edges 3 cycles apart inside the stun → only the first lands (opp_health 10→9). A third edge 9 cycles later lands (→8).
- Punch edges during O_REST, plus lpunch/rpunch rising together in O_WINDUP → REST edges cause no change; the simultaneous pair lands exactly one hit.
- Drive opp_health to 0 → WIN, user_win=1. start=1 → FIGHT with both healths reloaded to 10.
- reset=1 mid-O_WINDUP with user_health=5 → next cycle IDLE, healths=10, all flags 0, LFSR=8'hA5.
